// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with eight ops, zero/carry flags and an
// iterative shift-add multiplier, using a start/in_ready/done handshake.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous, active-high reset
//   start    request, accepted on an edge where start && in_ready
//   op       000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL
//   a, b     WIDTH-bit operands; b[SHW-1:0] is the shift amount for SHL/SHR
//   in_ready high while idle
//   done     one-cycle pulse after y/zero/carry are updated
//   y        2*WIDTH-bit registered result
//   zero     registered (y == 0) for the last completed op
//   carry    registered carry/borrow for the last completed op
module alu_seq #(
    parameter int WIDTH = 8,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               in_ready,
    output logic               done,
    output logic [2*WIDTH-1:0] y,
    output logic               zero,
    output logic               carry
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    // Counter holds WIDTH itself, so it needs one bit more than SHW.
    localparam logic [SHW:0] CNT_INIT = (SHW + 1)'(WIDTH);
    localparam logic [SHW:0] CNT_LAST = (SHW + 1)'(1);

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t             state;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic [SHW:0]       cnt;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] res;
    logic               res_c;
    logic [2*WIDTH-1:0] step;

    assign in_ready = (state == S_IDLE);

    // Single-cycle datapath; diff[WIDTH] is the borrow of a - b.
    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        diff  = {1'b0, a} - {1'b0, b};
        res   = '0;
        res_c = 1'b0;
        unique case (op)
            OP_ADD: begin
                res   = {{(WIDTH-1){1'b0}}, sum};
                res_c = sum[WIDTH];
            end
            OP_SUB: begin
                res   = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
                res_c = diff[WIDTH];
            end
            OP_AND: res = {{WIDTH{1'b0}}, a & b};
            OP_OR:  res = {{WIDTH{1'b0}}, a | b};
            OP_XOR: res = {{WIDTH{1'b0}}, a ^ b};
            OP_SHL: res = {{WIDTH{1'b0}}, a << b[SHW-1:0]};
            OP_SHR: res = {{WIDTH{1'b0}}, a >> b[SHW-1:0]};
            OP_MUL: res = '0;
            default: res = '0;
        endcase
    end

    // One shift-add step: add the shifted multiplicand when the current
    // multiplier LSB is set.
    always_comb begin
        step = acc;
        if (mplier[0]) begin
            step = acc + mcand;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            y      <= '0;
            zero   <= 1'b0;
            carry  <= 1'b0;
            done   <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        if (op == OP_MUL) begin
                            mcand  <= {{WIDTH{1'b0}}, a};
                            mplier <= b;
                            acc    <= '0;
                            cnt    <= CNT_INIT;
                            state  <= S_MUL;
                        end else begin
                            y     <= res;
                            zero  <= (res == '0);
                            carry <= res_c;
                            done  <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= step;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - 1'b1;
                    // Final step lands straight in y.
                    if (cnt == CNT_LAST) begin
                        y     <= step;
                        zero  <= (step == '0);
                        carry <= 1'b0;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq (WIDTH=8); expected results are
// queued when a request is accepted and checked when done pulses.
module tb_alu_seq;

    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic           start;
    logic [2:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           in_ready;
    logic           done;
    logic [2*W-1:0] y;
    logic           zero;
    logic           carry;

    typedef struct {
        logic [2*W-1:0] y;
        logic           z;
        logic           c;
        int             due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .op(op),
        .a(a),
        .b(b),
        .in_ready(in_ready),
        .done(done),
        .y(y),
        .zero(zero),
        .carry(carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] o,
                                   input logic [W-1:0] x,
                                   input logic [W-1:0] v);
        exp_t e;
        int   sh;
        e.c = 1'b0;
        e.due = 0;
        sh = int'(v) % W;
        case (o)
            3'd0: begin
                e.y = 16'(int'(x) + int'(v));
                e.c = (int'(x) + int'(v)) > 255;
            end
            3'd1: begin
                e.y = 16'((int'(x) - int'(v)) & 255);
                e.c = x < v;
            end
            3'd2: e.y = {8'h00, x & v};
            3'd3: e.y = {8'h00, x | v};
            3'd4: e.y = {8'h00, x ^ v};
            3'd5: e.y = 16'((int'(x) << sh) & 255);
            3'd6: e.y = 16'(int'(x) >> sh);
            default: e.y = 16'(int'(x) * int'(v));
        endcase
        e.z = (e.y == 16'h0000);
        return e;
    endfunction

    // Present a request at a negedge; it is accepted on the next edge
    // only if the DUT is ready.
    task automatic drive(input logic [2:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] v);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        op = o;
        a = x;
        b = v;
        if (in_ready) begin
            e = model(o, x, v);
            e.due = (o == 3'd7) ? cyc + 1 + W : cyc + 1;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        start = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    always @(posedge clk) begin
        exp_t e;
        cyc++;
        #1;
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                chk("spurious_done", 32'(done), 32'd0);
            end else begin
                e = q.pop_front();
                chk("done_cycle", 32'(cyc), 32'(e.due));
                chk("y", 32'(y), 32'(e.y));
                chk("zero", 32'(zero), 32'(e.z));
                chk("carry", 32'(carry), 32'(e.c));
            end
        end
    end

    initial begin
        int guard;
        rst = 1'b1;
        start = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_carry", 32'(carry), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        drive(3'd0, 8'hF0, 8'h20);
        drive(3'd0, 8'hFF, 8'h01);
        drive(3'd1, 8'h01, 8'h02);
        drive(3'd1, 8'h05, 8'h05);
        drive(3'd2, 8'hCC, 8'hAA);
        drive(3'd3, 8'hCC, 8'hAA);
        drive(3'd4, 8'hCC, 8'hAA);
        drive(3'd5, 8'h81, 8'h09);
        drive(3'd6, 8'h81, 8'h03);
        idle(3);

        // MUL FF*FF with an ADD request while busy that must be dropped.
        drive(3'd7, 8'hFF, 8'hFF);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            start = (i == 3);
            op = 3'd0;
            a = 8'h01;
            b = 8'h01;
            chk("mul_in_ready_low", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        start = 1'b0;
        chk("mul_in_ready_back", 32'(in_ready), 32'd1);
        idle(2);

        drive(3'd7, 8'h00, 8'h37);
        idle(W + 3);

        // Leave a non-zero result, then abort a MUL with reset.
        drive(3'd0, 8'h01, 8'h02);
        idle(2);
        drive(3'd7, 8'h12, 8'h34);
        repeat (3) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        chk("abort_y", 32'(y), 32'd0);
        chk("abort_zero", 32'(zero), 32'd0);
        chk("abort_carry", 32'(carry), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        drive(3'd0, 8'h01, 8'h01);
        idle(3);

        for (int i = 0; i < 30; i++) begin
            drive(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
        end
        idle(2);

        guard = 0;
        while (q.size() != 0 && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        chk("drain", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
